// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART transmitter.
//   state_t     - one-hot FSM state encoding
//   parity_e    - decoded parity mode
//   DBITS_MIN   - narrowest data field ever transmitted
//   par_decode  - maps the raw 2-bit parity field onto parity_e (11 -> none)
//   clamp_dbits - limits a requested data width to [DBITS_MIN, dmax]
package uart_pkg;

  localparam logic [3:0] DBITS_MIN = 4'd5;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  function automatic parity_e par_decode(input logic [1:0] p);
    case (p)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] clamp_dbits(input logic [3:0] d, input logic [3:0] dmax);
    if (d < DBITS_MIN)  return DBITS_MIN;
    else if (d > dmax)  return dmax;
    else                return d;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready word stream feeding the transmitter.
//   s_valid_i  source has a word
//   s_ready_o  transmitter holding buffer is empty
//   s_data_i   payload, LSB first
// master = stream source, slave = transmitter.
interface uart_tx_cfg_if #(parameter int DW_MAX = 9);
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DW_MAX-1:0] s_data_i;

  modport master (output s_valid_i, output s_data_i, input s_ready_o);
  modport slave  (input s_valid_i, input s_data_i, output s_ready_o);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer.
//   clk_i, rst_i  clock / async active-high reset
//   restart_i     forces the count back to 0 (start of a new frame)
//   div_i         bit period minus 1, in clock cycles
//   tick_o        high on the last cycle of each bit period
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] r_cnt;

  assign tick_o = (r_cnt == div_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_cnt <= '0;
    else if (restart_i || tick_o) r_cnt <= '0;
    else                        r_cnt <= r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a one-entry holding buffer.
//   clk_i, rst_i   clock / async active-high reset
//   cfg_div_i      bit period minus 1
//   cfg_dbits_i    data bits (clamped to 5..DW_MAX)
//   cfg_par_i      00/11 none, 01 even, 10 odd
//   cfg_stop2_i    two stop bits when set
//   s_if           word stream (slave side)
//   tx_o           registered serial line, idle high
//   busy_o         frame in progress or buffer occupied
//   done_o         last cycle of the final stop bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DW_MAX = 9,
  parameter int DIV_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [3:0]       cfg_dbits_i,
  input  logic [1:0]       cfg_par_i,
  input  logic             cfg_stop2_i,
  uart_tx_cfg_if.slave     s_if,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t            r_state;
  logic              r_buf_full;
  logic [DW_MAX-1:0] r_buf_data, r_sh;
  logic [DIV_W-1:0]  r_buf_div, r_div;
  logic [3:0]        r_buf_dbits, r_dbits, r_bitcnt;
  parity_e           r_buf_par, r_par;
  logic              r_buf_stop2, r_stop2, r_stopcnt, r_parity, r_tx;

  logic              w_tick, w_accept, w_frame_end, w_load;
  logic [DW_MAX-1:0] w_src_data;
  logic [DIV_W-1:0]  w_src_div;
  logic [3:0]        w_src_dbits;
  parity_e           w_src_par;
  logic              w_src_stop2;

  assign w_accept    = s_if.s_valid_i & ~r_buf_full;
  assign w_frame_end = (r_state == STOP) & w_tick & (r_stopcnt == r_stop2);
  // A word arriving on the frame-end cycle goes straight into the shifter so
  // the next start bit follows without an idle cycle.
  assign w_load      = r_buf_full ? ((r_state == IDLE) | w_frame_end)
                                  : (w_frame_end & s_if.s_valid_i);

  assign w_src_data  = r_buf_full ? r_buf_data  : s_if.s_data_i;
  assign w_src_div   = r_buf_full ? r_buf_div   : cfg_div_i;
  assign w_src_dbits = r_buf_full ? r_buf_dbits : clamp_dbits(cfg_dbits_i, 4'(DW_MAX));
  assign w_src_par   = r_buf_full ? r_buf_par   : par_decode(cfg_par_i);
  assign w_src_stop2 = r_buf_full ? r_buf_stop2 : cfg_stop2_i;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (w_load | (r_state == IDLE)),
    .div_i     (r_div),
    .tick_o    (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf_full  <= 1'b0;
      r_buf_data  <= '0;
      r_buf_div   <= '0;
      r_buf_dbits <= DBITS_MIN;
      r_buf_par   <= PAR_NONE;
      r_buf_stop2 <= 1'b0;
    end else if (w_load && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_accept && !w_load) begin
      r_buf_full  <= 1'b1;
      r_buf_data  <= s_if.s_data_i;
      r_buf_div   <= cfg_div_i;
      r_buf_dbits <= clamp_dbits(cfg_dbits_i, 4'(DW_MAX));
      r_buf_par   <= par_decode(cfg_par_i);
      r_buf_stop2 <= cfg_stop2_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_sh      <= '0;
      r_div     <= '0;
      r_dbits   <= DBITS_MIN;
      r_par     <= PAR_NONE;
      r_stop2   <= 1'b0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_parity  <= 1'b0;
    end else if (w_load) begin
      r_state  <= START;
      r_tx     <= 1'b0;
      r_sh     <= w_src_data;
      r_div    <= w_src_div;
      r_dbits  <= w_src_dbits;
      r_par    <= w_src_par;
      r_stop2  <= w_src_stop2;
      // seeding with 1 for odd parity turns the running XOR into its inverse
      r_parity <= (w_src_par == PAR_ODD);
    end else if (w_tick) begin
      case (r_state)
        IDLE: ;
        START: begin
          r_state  <= DATA;
          r_tx     <= r_sh[0];
          r_bitcnt <= '0;
        end
        DATA: begin
          r_parity <= r_parity ^ r_sh[0];
          if (r_bitcnt == r_dbits - 4'd1) begin
            if (r_par != PAR_NONE) begin
              r_state <= PARITY;
              r_tx    <= r_parity ^ r_sh[0];
            end else begin
              r_state   <= STOP;
              r_tx      <= 1'b1;
              r_stopcnt <= 1'b0;
            end
          end else begin
            r_sh     <= r_sh >> 1;
            r_tx     <= r_sh[1];
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        PARITY: begin
          r_state   <= STOP;
          r_tx      <= 1'b1;
          r_stopcnt <= 1'b0;
        end
        STOP: begin
          if (r_stopcnt == r_stop2) r_state <= IDLE;
          else                      r_stopcnt <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign s_if.s_ready_o = ~r_buf_full;
  assign tx_o           = r_tx;
  assign busy_o         = (r_state != IDLE) | r_buf_full;
  assign done_o         = w_frame_end;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg with hand-computed frames.
module tb_uart_tx_cfg;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] cfg_div_i;
  logic [3:0]  cfg_dbits_i;
  logic [1:0]  cfg_par_i;
  logic        cfg_stop2_i;
  logic        tx_o, busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_cfg_if #(.DW_MAX(9)) u_if ();

  uart_tx_cfg #(.DW_MAX(9), .DIV_W(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_dbits_i (cfg_dbits_i),
    .cfg_par_i   (cfg_par_i),
    .cfg_stop2_i (cfg_stop2_i),
    .s_if        (u_if.slave),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one word while idle; returns just after the edge that starts the frame.
  task automatic send(input logic [8:0] d, input logic [15:0] div, input logic [3:0] db,
                      input logic [1:0] par, input logic st2);
    @(negedge clk_i);
    cfg_div_i = div; cfg_dbits_i = db; cfg_par_i = par; cfg_stop2_i = st2;
    u_if.s_valid_i = 1'b1;
    u_if.s_data_i  = d;
    @(posedge clk_i);
    @(negedge clk_i);
    u_if.s_valid_i = 1'b0;
    chk("accept_ready", 32'(u_if.s_ready_o), 0);
    chk("accept_busy", 32'(busy_o), 1);
    chk("accept_tx_idle", 32'(tx_o), 1);
    @(posedge clk_i);
  endtask

  // bits[0] is the start bit; each bit must hold for per cycles, done only on the very last.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits, input int per);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk_i);
        chk({tag, "_tx"}, 32'(tx_o), 32'(bits[i]));
        chk({tag, "_done"}, 32'(done_o), 32'(i == nbits - 1 && c == per - 1));
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cfg_div_i = 16'd0; cfg_dbits_i = 4'd8; cfg_par_i = 2'b00; cfg_stop2_i = 1'b0;
    u_if.s_valid_i = 1'b0;
    u_if.s_data_i  = 9'h000;
    #12;
    chk("rst_tx", 32'(tx_o), 1);
    chk("rst_ready", 32'(u_if.s_ready_o), 1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: div=3, 8N1, 0xA5
    send(9'h0A5, 16'd3, 4'd8, 2'b00, 1'b0);
    run_frame("t1", 16'({1'b1, 8'hA5, 1'b0}), 10, 4);
    @(negedge clk_i);
    chk("t1_busy_after", 32'(busy_o), 0);
    chk("t1_done_after", 32'(done_o), 0);

    // 2: div=0, 7E1 and 7O1 on 0x55 (four ones -> even 0, odd 1)
    send(9'h055, 16'd0, 4'd7, 2'b01, 1'b0);
    run_frame("t2e", 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, 1);
    send(9'h055, 16'd0, 4'd7, 2'b10, 1'b0);
    run_frame("t2o", 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, 1);

    // 3: div=1, 8N2, valid held with 0x00 then 0xFF, back-to-back frames
    @(negedge clk_i);
    cfg_div_i = 16'd1; cfg_dbits_i = 4'd8; cfg_par_i = 2'b00; cfg_stop2_i = 1'b1;
    u_if.s_valid_i = 1'b1;
    u_if.s_data_i  = 9'h000;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t3_ready_full", 32'(u_if.s_ready_o), 0);
    u_if.s_data_i = 9'h0FF;
    @(posedge clk_i);
    fork
      begin
        run_frame("t3a", 16'({2'b11, 8'h00, 1'b0}), 11, 2);
        run_frame("t3b", 16'({2'b11, 8'hFF, 1'b0}), 11, 2);
      end
      begin
        @(negedge clk_i);
        chk("t3_ready_refill", 32'(u_if.s_ready_o), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        u_if.s_valid_i = 1'b0;
        chk("t3_ready_held", 32'(u_if.s_ready_o), 0);
        chk("t3_busy_held", 32'(busy_o), 1);
      end
    join
    @(negedge clk_i);
    chk("t3_busy_after", 32'(busy_o), 0);

    // 4: cfg changes during DATA of frame 1; frame 2 picks up div=7, dbits=5
    send(9'h096, 16'd3, 4'd8, 2'b00, 1'b0);
    fork
      run_frame("t4a", 16'({1'b1, 8'h96, 1'b0}), 10, 4);
      begin
        repeat (6) @(negedge clk_i);
        cfg_div_i = 16'd7; cfg_dbits_i = 4'd5;
        u_if.s_valid_i = 1'b1;
        u_if.s_data_i  = 9'h013;
        @(posedge clk_i);
        @(negedge clk_i);
        u_if.s_valid_i = 1'b0;
        chk("t4_ready_full", 32'(u_if.s_ready_o), 0);
      end
    join
    run_frame("t4b", 16'({1'b1, 5'h13, 1'b0}), 7, 8);
    @(negedge clk_i);
    chk("t4_busy_after", 32'(busy_o), 0);

    // 5: reset during DATA bit 4 with a word waiting in the buffer
    send(9'h00F, 16'd3, 4'd8, 2'b00, 1'b0);
    @(negedge clk_i);
    u_if.s_valid_i = 1'b1;
    u_if.s_data_i  = 9'h077;
    @(posedge clk_i);
    @(negedge clk_i);
    u_if.s_valid_i = 1'b0;
    chk("t5_buf_full", 32'(u_if.s_ready_o), 0);
    repeat (20) @(negedge clk_i);
    chk("t5_pre_tx_bit4", 32'(tx_o), 0);
    chk("t5_pre_busy", 32'(busy_o), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("t5_rst_tx", 32'(tx_o), 1);
    chk("t5_rst_busy", 32'(busy_o), 0);
    chk("t5_rst_ready", 32'(u_if.s_ready_o), 1);
    chk("t5_rst_done", 32'(done_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("t5_idle_tx", 32'(tx_o), 1);
    chk("t5_idle_busy", 32'(busy_o), 0);
    send(9'h03C, 16'd3, 4'd8, 2'b00, 1'b0);
    run_frame("t5", 16'({1'b1, 8'h3C, 1'b0}), 10, 4);

    // 6: dbits clamping; upper payload bits ignored
    send(9'h1FA, 16'd0, 4'd3, 2'b00, 1'b0);
    run_frame("t6a", 16'({1'b1, 5'h1A, 1'b0}), 7, 1);
    send(9'h1FF, 16'd1, 4'd12, 2'b00, 1'b0);
    run_frame("t6b", 16'({1'b1, 9'h1FF, 1'b0}), 11, 2);
    @(negedge clk_i);
    chk("t6_busy_after", 32'(busy_o), 0);
    chk("t6_tx_after", 32'(tx_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
